// File: rtl/writeback_stage_if.sv
// Writeback stage bus: pipeline-side inputs (i_*) and register-file / debug outputs (o_*).
//   master : drives i_* (previous pipeline stage / debug unit), observes o_*
//   slave  : the writeback stage itself
interface writeback_stage_if #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_REGISTER = 5
);
  logic                   i_valid;
  logic                   i_exec_mode;
  logic                   i_step;
  logic                   i_mem_to_reg;
  logic                   i_reg_write;
  logic                   i_halt;
  logic [1:0]             i_jump;
  logic [NB_DATA-1:0]     i_read_data;
  logic [NB_DATA-1:0]     i_alu_result;
  logic [NB_DATA-1:0]     i_pc_4;
  logic [NB_REGISTER-1:0] i_rt_rd;

  logic                   o_reg_write;
  logic [NB_REGISTER-1:0] o_write_register;
  logic [NB_DATA-1:0]     o_write_data;
  logic                   o_halt;
  logic                   o_step_done;
  logic [NB_DATA-1:0]     o_instr_count;

  modport master (
    output i_valid, i_exec_mode, i_step, i_mem_to_reg, i_reg_write, i_halt,
           i_jump, i_read_data, i_alu_result, i_pc_4, i_rt_rd,
    input  o_reg_write, o_write_register, o_write_data, o_halt, o_step_done,
           o_instr_count
  );

  modport slave (
    input  i_valid, i_exec_mode, i_step, i_mem_to_reg, i_reg_write, i_halt,
           i_jump, i_read_data, i_alu_result, i_pc_4, i_rt_rd,
    output o_reg_write, o_write_register, o_write_data, o_halt, o_step_done,
           o_instr_count
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: selects register-file write data/index, issues a one-cycle
// write strobe per retired instruction, tracks HALT, step acknowledge and a
// saturating retired-instruction counter.
// Ports:
//   i_clock  : clock, all state on rising edge
//   i_reset  : synchronous active-high reset
//   bus      : writeback_stage_if.slave (pipeline inputs i_*, register-file/debug outputs o_*)
module writeback_stage #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_REGISTER = 5
) (
  input  logic              i_clock,
  input  logic              i_reset,
  writeback_stage_if.slave  bus
);

  localparam logic [1:0] JUMP_JAL  = 2'b10;
  localparam int unsigned LINK_REG = 31;

  logic                   r_reg_write;
  logic [NB_REGISTER-1:0] r_write_register;
  logic [NB_DATA-1:0]     r_write_data;
  logic                   r_halt;
  logic                   r_step_done;
  logic [NB_DATA-1:0]     r_instr_count;

  logic                   w_advance;
  logic [NB_REGISTER-1:0] w_wr_index;
  logic [NB_DATA-1:0]     w_wr_data;
  logic                   w_wr_enable;

  // An instruction retires only when loaded, permitted by the run mode and not halted.
  assign w_advance = bus.i_valid && (!bus.i_exec_mode || bus.i_step) && !r_halt;

  // JAL links into r31; JALR keeps its own destination but still writes the return address.
  assign w_wr_index = (bus.i_jump == JUMP_JAL) ? NB_REGISTER'(LINK_REG) : bus.i_rt_rd;
  assign w_wr_data  = bus.i_jump[1]     ? bus.i_pc_4      :
                      bus.i_mem_to_reg  ? bus.i_read_data : bus.i_alu_result;

  // r0 is hardwired; HALT never writes.
  assign w_wr_enable = bus.i_reg_write && !bus.i_halt && (w_wr_index != '0);

  // Pipeline state; strobes are recomputed every cycle so stalls never repeat a write.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_reg_write      <= 1'b0;
      r_write_register <= '0;
      r_write_data     <= '0;
      r_halt           <= 1'b0;
      r_step_done      <= 1'b0;
      r_instr_count    <= '0;
    end else begin
      r_reg_write <= w_advance && w_wr_enable;
      r_step_done <= w_advance && bus.i_exec_mode;
      if (w_advance) begin
        r_write_register <= w_wr_index;
        r_write_data     <= w_wr_data;
        if (bus.i_halt) begin
          r_halt <= 1'b1;
        end
        if (r_instr_count != '1) begin
          r_instr_count <= r_instr_count + NB_DATA'(1);
        end
      end
    end
  end

  assign bus.o_reg_write      = r_reg_write;
  assign bus.o_write_register = r_write_register;
  assign bus.o_write_data     = r_write_data;
  assign bus.o_halt           = r_halt;
  assign bus.o_step_done      = r_step_done;
  assign bus.o_instr_count    = r_instr_count;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  localparam int unsigned NB_DATA     = 32;
  localparam int unsigned NB_REGISTER = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_stage_if #(.NB_DATA(NB_DATA), .NB_REGISTER(NB_REGISTER)) bus ();

  writeback_stage #(.NB_DATA(NB_DATA), .NB_REGISTER(NB_REGISTER)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: architectural view of what the register file and debug unit see.
  bit      m_rw, m_sd, m_halt;
  int      m_idx;
  longint  m_data;
  longint  m_count;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit mode, input bit step, input bit m2r,
                       input bit rw, input bit h, input bit [1:0] j,
                       input logic [31:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [4:0] rt);
    bus.i_valid = v;      bus.i_exec_mode = mode; bus.i_step = step;
    bus.i_mem_to_reg = m2r; bus.i_reg_write = rw; bus.i_halt = h;
    bus.i_jump = j;       bus.i_read_data = rd;   bus.i_alu_result = alu;
    bus.i_pc_4 = pc4;     bus.i_rt_rd = rt;
  endtask

  // Predict the effect of the coming edge, take the edge, then compare every output.
  task automatic tick(input string tag);
    bit retire;
    int idx;
    retire = bus.i_valid && (!bus.i_exec_mode || bus.i_step) && !m_halt;
    if (rst) begin
      m_rw = 0; m_sd = 0; m_halt = 0; m_idx = 0; m_data = 0; m_count = 0;
    end else begin
      case (bus.i_jump)
        2'b10:   idx = 31;
        default: idx = int'(bus.i_rt_rd);
      endcase
      m_rw = retire && bus.i_reg_write && !bus.i_halt && idx != 0;
      m_sd = retire && bus.i_exec_mode;
      if (retire) begin
        m_idx = idx;
        if (bus.i_jump == 2'b10 || bus.i_jump == 2'b11) m_data = longint'(bus.i_pc_4);
        else if (bus.i_mem_to_reg)                      m_data = longint'(bus.i_read_data);
        else                                            m_data = longint'(bus.i_alu_result);
        m_count = (m_count + 1 > CNT_MAX) ? CNT_MAX : m_count + 1;
        if (bus.i_halt) m_halt = 1;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".reg_write"}, 64'(bus.o_reg_write),      64'(m_rw));
    chk({tag, ".wr_reg"},    64'(bus.o_write_register), 64'(m_idx));
    chk({tag, ".wr_data"},   64'(bus.o_write_data),     64'(m_data));
    chk({tag, ".halt"},      64'(bus.o_halt),           64'(m_halt));
    chk({tag, ".step_done"}, 64'(bus.o_step_done),      64'(m_sd));
    chk({tag, ".count"},     64'(bus.o_instr_count),    64'(m_count));
  endtask

  task automatic idle(input bit mode);
    drive(1, mode, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    logic [31:0] cnt_before;
    // Reset with an advance-capable stimulus present.
    drive(1, 0, 0, 0, 1, 0, 2'b00, 32'h1111_1111, 32'h2222_2222, 32'h4, 5'd9);
    rst = 1;
    tick("reset0");
    tick("reset1");
    chk("reset.count_zero", 64'(bus.o_instr_count), 64'd0);
    rst = 0;

    // Load from memory into r7, then stall.
    drive(1, 0, 0, 1, 1, 0, 2'b00, 32'hDEAD_BEEF, 32'h1234_5678, 32'h8, 5'd7);
    tick("lw");
    chk("lw.data_const", 64'(bus.o_write_data), 64'hDEAD_BEEF);
    chk("lw.reg_const",  64'(bus.o_write_register), 64'd7);
    chk("lw.count_const", 64'(bus.o_instr_count), 64'd1);
    drive(0, 0, 0, 1, 1, 0, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h8, 5'd7);
    tick("lw_stall");
    chk("lw_stall.no_write", 64'(bus.o_reg_write), 64'd0);

    // JAL links into r31; JALR keeps rd.
    drive(1, 0, 0, 0, 1, 0, 2'b10, 32'h0, 32'h99, 32'h0000_0040, 5'd3);
    tick("jal");
    chk("jal.reg_const", 64'(bus.o_write_register), 64'd31);
    drive(1, 0, 0, 0, 1, 0, 2'b11, 32'h0, 32'h99, 32'h0000_0040, 5'd3);
    tick("jalr");
    chk("jalr.data_const", 64'(bus.o_write_data), 64'h40);

    // Write to r0 is suppressed but the instruction still retires.
    drive(1, 0, 0, 0, 1, 0, 2'b00, 32'h0, 32'd5, 32'h0, 5'd0);
    tick("r0");

    // Step mode: 10 idle cycles, one step pulse, then idle.
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 0, 1, 0, 2'b00, 32'h0, 32'hA0 + 32'(i), 32'h0, 5'd12);
      tick("step_wait");
    end
    drive(1, 1, 1, 0, 1, 0, 2'b00, 32'h0, 32'hCAFE, 32'h0, 5'd12);
    tick("step_go");
    chk("step.done_const", 64'(bus.o_step_done), 64'd1);
    idle(1);
    tick("step_after");
    // Step held high for 3 cycles: three advances.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 1, 0, 2'b00, 32'h0, 32'h100 + 32'(i), 32'h0, 5'd13);
      tick("step_held");
    end
    // Back to continuous mode mid-run.
    drive(1, 0, 0, 0, 1, 0, 2'b00, 32'h0, 32'h777, 32'h0, 5'd14);
    tick("cont_again");

    // Random run against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 99) < 85, ($urandom_range(0, 99) < 30),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 3,
            2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
            5'($urandom_range(0, 31)));
      tick("rand");
    end
    rst = 0;

    // HALT then five more write attempts: sticky, nothing retires.
    idle(0); rst = 1; tick("pre_halt_rst"); rst = 0;
    drive(1, 0, 0, 0, 1, 0, 2'b00, 32'h0, 32'h55, 32'h0, 5'd4);
    tick("pre_halt");
    drive(1, 0, 0, 0, 1, 1, 2'b00, 32'h0, 32'h66, 32'h0, 5'd5);
    tick("halt");
    cnt_before = bus.o_instr_count;
    chk("halt.count_const", 64'(cnt_before), 64'd2);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 1, 0, 2'b00, 32'h0, 32'h70 + 32'(i), 32'h0, 5'd6);
      tick("post_halt");
    end
    chk("post_halt.sticky", 64'(bus.o_halt), 64'd1);
    rst = 1; tick("halt_rst"); rst = 0;
    chk("halt_rst.halt_clear", 64'(bus.o_halt), 64'd0);
    // First instruction after reset behaves like power-up.
    drive(1, 0, 0, 0, 1, 0, 2'b00, 32'h0, 32'h88, 32'h0, 5'd8);
    tick("after_rst");
    chk("after_rst.count_const", 64'(bus.o_instr_count), 64'd1);

    // Reset wins over a simultaneous advance.
    rst = 1;
    drive(1, 0, 0, 0, 1, 0, 2'b00, 32'h0, 32'h99, 32'h0, 5'd9);
    tick("rst_vs_adv");
    chk("rst_vs_adv.no_write", 64'(bus.o_reg_write), 64'd0);
    rst = 0;
    idle(0);
    tick("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, meaning data/PC width.
REQ-002 The block SHALL have parameter NB_REGISTER, default 5, meaning register-index width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: i_clock  in  1  clock, all state on rising edge; i_reset  in  1  synchronous active-high reset.
REQ-004 Ports SHALL be (name  dir  width  meaning):
 i_valid  in  1  pipeline valid / program loaded
 i_exec_mode  in  1  0 = continuous, 1 = step mode
 i_step  in  1  single-step request (step mode)
 i_mem_to_reg  in  1  select memory read data
 i_reg_write  in  1  instruction writes register file
 i_halt  in  1  instruction is HALT
 i_jump  in  2  00 none, 01 J/JR, 10 JAL, 11 JALR
 i_read_data  in  NB_DATA  data memory read value
 i_alu_result  in  NB_DATA  ALU result
 i_pc_4  in  NB_DATA  return address of the instruction
 i_rt_rd  in  NB_REGISTER  destination register index
 o_reg_write  out  1  register-file write strobe
 o_write_register  out  NB_REGISTER  register-file write index
 o_write_data  out  NB_DATA  register-file write data (also forwarding source)
 o_halt  out  1  sticky program-end flag
 o_step_done  out  1  step acknowledge pulse
 o_instr_count  out  NB_DATA  retired-instruction count

Function
REQ-005 advance SHALL be i_valid && (!i_exec_mode || i_step) && !o_halt.
REQ-006 Write data SHALL be i_pc_4 when i_jump is 10 or 11, else i_read_data when i_mem_to_reg=1, else i_alu_result.
REQ-007 Write index SHALL be 31 when i_jump=10, else i_rt_rd.
REQ-008 On a clock edge with advance=1, o_write_register and o_write_data SHALL load the values of REQ-006/007 (latency 1 cycle); otherwise they SHALL hold.
REQ-009 o_reg_write SHALL be 1 for exactly the cycle after an advance whose i_reg_write=1, i_halt=0 and write index != 0; 0 in every other cycle (write to r0 suppressed, no repeated writes while stalled).
REQ-010 On an advance with i_halt=1, o_halt SHALL become 1 the next cycle and remain 1 until reset; no further advances, writes or count increments SHALL occur.
REQ-011 o_instr_count SHALL increment by 1 on each advance (the HALT instruction included), saturating at all-ones.
REQ-012 o_step_done SHALL be a one-cycle pulse in the cycle after an advance taken with i_exec_mode=1; 0 in continuous mode.
REQ-013 i_step held high across several cycles SHALL advance once per cycle it is high; no edge detection inside this block.
REQ-014 i_valid=0 SHALL freeze all state (no advance, o_reg_write=0, o_step_done=0).
REQ-015 Switching i_exec_mode mid-run SHALL take effect at the next edge with no lost or duplicated writes.

Reset
REQ-016 On a clock edge with i_reset=1, all outputs SHALL become 0 (o_reg_write, o_write_register, o_write_data, o_halt, o_step_done, o_instr_count) regardless of other inputs.
REQ-017 Reset SHALL take priority over a simultaneous advance or halt; reset asserted mid-run SHALL discard the in-flight instruction (no write issued).
REQ-018 After reset is released, the first advance SHALL behave identically to the first instruction after power-up, including clearing a prior halt.

Verification
REQ-019 Continuous mode, advance with i_reg_write=1, i_mem_to_reg=1, i_read_data=0xDEADBEEF, i_rt_rd=7 -> next cycle o_reg_write=1, o_write_register=7, o_write_data=0xDEADBEEF, o_instr_count=1; following stalled cycle o_reg_write=0.
REQ-020 Advance with i_jump=10, i_pc_4=0x0000_0040, i_reg_write=1, i_rt_rd=3 -> o_write_register=31, o_write_data=0x40; with i_jump=11 same stimulus -> o_write_register=3, o_write_data=0x40.
REQ-021 Advance with i_reg_write=1, i_rt_rd=0, i_alu_result=5 -> o_reg_write stays 0, o_instr_count increments.
REQ-022 Step mode: i_step low 10 cycles then one-cycle pulse -> exactly one write, o_step_done high one cycle, o_instr_count +1.
REQ-023 Advance with i_halt=1 then 5 more advances carrying i_reg_write=1 -> o_halt=1 sticky, no o_reg_write pulses, o_instr_count unchanged after HALT; i_reset for 1 cycle -> all outputs 0.
REQ-024 i_reset=1 in the same cycle as an advance with i_reg_write=1 -> next cycle o_reg_write=0, o_instr_count=0.
